fmap_streamer: RTL

Frame source that drives the pixel-stream interface consumed by the convolution layer: pixel_in, pixel_valid and frame_start.
- A host loads one multi-channel frame into an internal buffer.
- On start, the block replays that frame in raster order, with optional inter-row gaps, downstream stall and a post-frame drain period.
- It sits between the host/DMA load path and the first conv stage; it is also reused between layers to re-emit stored feature maps.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/fmap_buffer.sv | 31 +++
 rtl/fmap_streamer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming blocks: default sample geometry and the
// frame-source FSM encoding. Pixel words pack channel i at bits [(i+1)*DW-1 -: DW].
package cnn_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int IN_CHANNEL_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOF    = 3'd1,
        ST_STREAM = 3'd2,
        ST_GAP    = 3'd3,
        ST_TAIL   = 3'd4,
        ST_FIN    = 3'd5
    } fsm_state_e;

endpackage

// File: rtl/fmap_buffer.sv
// Simple dual-port frame RAM: synchronous write, registered 1-cycle read.
// Contents are deliberately not reset so a stored frame survives rst_n.
module fmap_buffer #(
    parameter int WORD_W = 24,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fmap_streamer.sv
// Frame source for the conv pipeline: replays a host-loaded frame in raster order
// with optional row gaps, downstream stall and a post-frame drain period.
module fmap_streamer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int IN_CHANNEL  = IN_CHANNEL_DEF,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int ROW_GAP     = 0,
    parameter int TAIL_CYCLES = 34,
    parameter int ADDR_W      = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0] wr_data,
    input  logic                             start,
    input  logic                             stall,
    output logic [IN_CHANNEL*DATA_WIDTH-1:0] pixel_in,
    output logic                             pixel_valid,
    output logic                             frame_start,
    output logic                             busy,
    output logic                             done,
    output logic                             wr_err,
    output logic [2:0]                       dbg_state
);

    localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int WORD_W = IN_CHANNEL * DATA_WIDTH;
    localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int GAP_W  = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
    localparam int TAIL_W = (TAIL_CYCLES > 0) ? $clog2(TAIL_CYCLES + 1) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
    // TAIL spans the cycle in which the last pixel lands plus TAIL_CYCLES idle cycles.
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES);

    fsm_state_e        state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [GAP_W-1:0]  gap_q;
    logic [TAIL_W-1:0] tail_q;
    logic              valid_q;
    logic              frame_start_q;
    logic              busy_q;
    logic              done_q;
    logic              wr_err_q;

    logic              issue;
    logic              buf_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;

    assign issue   = (state_q == ST_STREAM) && !stall;
    assign buf_we  = wr_en && (state_q == ST_IDLE) && (32'(wr_addr) < NPIX);
    assign rd_addr = ADDR_W'(int'(row_q) * IMG_WIDTH + int'(col_q));

    fmap_buffer #(
        .WORD_W (WORD_W),
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (issue),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            gap_q         <= '0;
            tail_q        <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            valid_q       <= issue;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            if (wr_en && busy_q) begin
                wr_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q       <= ST_SOF;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                        wr_err_q      <= 1'b0;
                    end
                end
                ST_SOF: begin
                    col_q   <= '0;
                    row_q   <= '0;
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (!stall) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                tail_q  <= '0;
                                state_q <= ST_TAIL;
                            end else begin
                                row_q <= row_q + 1'b1;
                                if (ROW_GAP > 0) begin
                                    gap_q   <= '0;
                                    state_q <= ST_GAP;
                                end
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // The gap is a fixed count; stall does not stretch it.
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_STREAM;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (tail_q == TAIL_LAST) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tail_q <= tail_q + 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pixel_in    = valid_q ? rd_data : '0;
    assign pixel_valid = valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wr_err      = wr_err_q;
    assign dbg_state   = state_q;

endmodule
